// File: rtl/lsu_if.sv
// Core-side load/store bus between a single-cycle pipeline and the LSU.
interface lsu_if;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_st_data;
  logic        i_lsu_wren;
  logic [2:0]  i_funct3;
  logic [31:0] o_ld_data;
  logic        o_misaligned;

  // Core side: presents the access, consumes the load result.
  modport master (
    output i_lsu_addr, i_st_data, i_lsu_wren, i_funct3,
    input  o_ld_data, o_misaligned
  );

  // LSU side.
  modport slave (
    input  i_lsu_addr, i_st_data, i_lsu_wren, i_funct3,
    output o_ld_data, o_misaligned
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: 8 KiB data memory plus memory-mapped LED/HEX/LCD/switch/button I/O.
// Loads are combinational; stores commit on the rising clock edge.
module lsu (
  input  logic        i_clk,
  input  logic        i_rst_n,
  lsu_if.slave        bus,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_lcd,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7
);

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BTN_W      = 4;
  localparam int unsigned DMEM_AW    = 11;
  localparam int unsigned DMEM_WORDS = 2048;

  // Word addresses (byte address >> 2) of the peripheral registers.
  localparam logic [13:0] WA_LEDR   = 14'h1C00;
  localparam logic [13:0] WA_LEDG   = 14'h1C04;
  localparam logic [13:0] WA_HEX_LO = 14'h1C08;
  localparam logic [13:0] WA_HEX_HI = 14'h1C09;
  localparam logic [13:0] WA_LCD    = 14'h1C0C;
  localparam logic [13:0] WA_SW     = 14'h1E00;
  localparam logic [13:0] WA_BTN    = 14'h1E04;

  // HEX bytes keep only segment bits [6:0].
  localparam logic [DATA_W-1:0] HEX_MASK = 32'h7F7F_7F7F;

  logic [DATA_W-1:0] dmem_q [DMEM_WORDS];

  logic [DATA_W-1:0] ledr_q, ledr_d;
  logic [DATA_W-1:0] ledg_q, ledg_d;
  logic [DATA_W-1:0] lcd_q, lcd_d;
  logic [DATA_W-1:0] hex_lo_q, hex_lo_d;
  logic [DATA_W-1:0] hex_hi_q, hex_hi_d;
  logic [DATA_W-1:0] sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [BTN_W-1:0]  btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;

  logic [DATA_W-1:0]  addr;
  logic [13:0]        word_a;
  logic [DMEM_AW-1:0] dmem_idx;
  logic               upper_zero;
  logic               sel_dmem, sel_ledr, sel_ledg, sel_hex_lo, sel_hex_hi;
  logic               sel_lcd, sel_sw, sel_btn;
  logic               misaligned;
  logic [DATA_W-1:0]  rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [DATA_W-1:0]  ld_data;
  logic [3:0]         be;
  logic [DATA_W-1:0]  wmask;
  logic [DATA_W-1:0]  wdata;
  logic               wr_en;
  logic               dmem_we;

  // Address decode on the low half-word; the upper half must be zero.
  always_comb begin
    addr       = bus.i_lsu_addr;
    word_a     = addr[15:2];
    dmem_idx   = addr[12:2];
    upper_zero = (addr[31:16] == 16'd0);
    sel_dmem   = upper_zero && (addr[15:13] == 3'b001);
    sel_ledr   = upper_zero && (word_a == WA_LEDR);
    sel_ledg   = upper_zero && (word_a == WA_LEDG);
    sel_hex_lo = upper_zero && (word_a == WA_HEX_LO);
    sel_hex_hi = upper_zero && (word_a == WA_HEX_HI);
    sel_lcd    = upper_zero && (word_a == WA_LCD);
    sel_sw     = upper_zero && (word_a == WA_SW);
    sel_btn    = upper_zero && (word_a == WA_BTN);
  end

  // Alignment check; illegal funct3 codes are flagged the same way.
  always_comb begin
    misaligned = 1'b1;
    unique case (bus.i_funct3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = addr[0];
      3'b010:         misaligned = (addr[1:0] != 2'b00);
      default:        misaligned = 1'b1;
    endcase
  end

  // Read the addressed word; synchronized pins read as 0 while reset is held.
  always_comb begin
    rd_word = '0;
    if (sel_dmem)        rd_word = dmem_q[dmem_idx];
    else if (sel_ledr)   rd_word = ledr_q;
    else if (sel_ledg)   rd_word = ledg_q;
    else if (sel_hex_lo) rd_word = hex_lo_q;
    else if (sel_hex_hi) rd_word = hex_hi_q;
    else if (sel_lcd)    rd_word = lcd_q;
    else if (sel_sw)     rd_word = i_rst_n ? sw_sync_q : '0;
    else if (sel_btn)    rd_word = i_rst_n ? DATA_W'(btn_sync_q) : '0;
  end

  // Lane select and sign/zero extension of the load result.
  always_comb begin
    rd_byte = 8'(rd_word >> {addr[1:0], 3'b000});
    rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = '0;
    unique case (bus.i_funct3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ld_data = {24'd0, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_data = {16'd0, rd_half};
      3'b010:  ld_data = rd_word;
      default: ld_data = '0;
    endcase
    if (misaligned) ld_data = '0;
  end

  assign bus.o_ld_data    = ld_data;
  assign bus.o_misaligned = misaligned;

  // Byte enables and lane-replicated store data.
  always_comb begin
    be    = 4'b0000;
    wdata = bus.i_st_data;
    unique case (bus.i_funct3[1:0])
      2'b00: begin
        be    = 4'(4'b0001 << addr[1:0]);
        wdata = {4{bus.i_st_data[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.i_st_data[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    wmask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    wr_en   = bus.i_lsu_wren && i_rst_n && !misaligned;
    dmem_we = wr_en && sel_dmem;
  end

  // Next-state for peripheral registers and pin synchronizers.
  always_comb begin
    ledr_d     = ledr_q;
    ledg_d     = ledg_q;
    lcd_d      = lcd_q;
    hex_lo_d   = hex_lo_q;
    hex_hi_d   = hex_hi_q;
    sw_meta_d  = i_io_sw;
    sw_sync_d  = sw_meta_q;
    btn_meta_d = i_io_btn;
    btn_sync_d = btn_meta_q;
    if (wr_en) begin
      if (sel_ledr)   ledr_d   = (ledr_q & ~wmask) | (wdata & wmask);
      if (sel_ledg)   ledg_d   = (ledg_q & ~wmask) | (wdata & wmask);
      if (sel_lcd)    lcd_d    = (lcd_q & ~wmask) | (wdata & wmask);
      if (sel_hex_lo) hex_lo_d = ((hex_lo_q & ~wmask) | (wdata & wmask)) & HEX_MASK;
      if (sel_hex_hi) hex_hi_d = ((hex_hi_q & ~wmask) | (wdata & wmask)) & HEX_MASK;
    end
  end

  // Peripheral and synchronizer registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ledr_q     <= '0;
      ledg_q     <= '0;
      lcd_q      <= '0;
      hex_lo_q   <= '0;
      hex_hi_q   <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      lcd_q      <= lcd_d;
      hex_lo_q   <= hex_lo_d;
      hex_hi_q   <= hex_hi_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
    end
  end

  // Data memory: byte-lane writes, contents deliberately not reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (dmem_we && be[b]) dmem_q[dmem_idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;
  assign o_io_hex0 = hex_lo_q[6:0];
  assign o_io_hex1 = hex_lo_q[14:8];
  assign o_io_hex2 = hex_lo_q[22:16];
  assign o_io_hex3 = hex_lo_q[30:24];
  assign o_io_hex4 = hex_hi_q[6:0];
  assign o_io_hex5 = hex_hi_q[14:8];
  assign o_io_hex6 = hex_hi_q[22:16];
  assign o_io_hex7 = hex_hi_q[30:24];

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: scoreboarded loads, stores, I/O mirrors, reset.
module tb_lsu;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;
  localparam logic [2:0] F_XX = 3'b011;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_io_sw;
  logic [3:0]  i_io_btn;
  logic [31:0] o_io_ledr, o_io_ledg, o_io_lcd;
  logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
  logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  lsu_if bus ();

  lsu dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .bus       (bus.slave),
    .i_io_sw   (i_io_sw),
    .i_io_btn  (i_io_btn),
    .o_io_ledr (o_io_ledr),
    .o_io_ledg (o_io_ledg),
    .o_io_lcd  (o_io_lcd),
    .o_io_hex0 (o_io_hex0),
    .o_io_hex1 (o_io_hex1),
    .o_io_hex2 (o_io_hex2),
    .o_io_hex3 (o_io_hex3),
    .o_io_hex4 (o_io_hex4),
    .o_io_hex5 (o_io_hex5),
    .o_io_hex6 (o_io_hex6),
    .o_io_hex7 (o_io_hex7)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One-cycle store; returns 1 time unit after the committing edge.
  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    bus.i_lsu_wren = 1'b1;
    bus.i_funct3   = f3;
    bus.i_lsu_addr = addr;
    bus.i_st_data  = data;
    @(posedge i_clk);
    #1;
    bus.i_lsu_wren = 1'b0;
  endtask

  // Present a load, scoreboard the expected result, compare, then advance a cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp);
    bus.i_lsu_wren = 1'b0;
    bus.i_funct3   = f3;
    bus.i_lsu_addr = addr;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #2;
    check(tag_q.pop_front(), bus.o_ld_data, exp_q.pop_front());
    @(posedge i_clk);
    #1;
  endtask

  // Present an access and check the misaligned flag before the edge.
  task automatic probe_mis(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic wren, input logic exp_mis);
    bus.i_lsu_wren = wren;
    bus.i_funct3   = f3;
    bus.i_lsu_addr = addr;
    bus.i_st_data  = 32'h1234_5678;
    #2;
    check(tag, {31'd0, bus.o_misaligned}, {31'd0, exp_mis});
    @(posedge i_clk);
    #1;
    bus.i_lsu_wren = 1'b0;
  endtask

  initial begin
    i_rst_n        = 1'b0;
    i_io_sw        = 32'h0;
    i_io_btn       = 4'h0;
    bus.i_lsu_addr = 32'h0;
    bus.i_st_data  = 32'h0;
    bus.i_lsu_wren = 1'b0;
    bus.i_funct3   = F_W;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_ledr", o_io_ledr, 32'h0);
    check("rst_hex0", 32'(o_io_hex0), 32'h0);
    i_rst_n = 1'b1;

    // Extension and lane selection.
    do_store(F_W, 32'h2000, 32'h8765_43F1);
    do_load("lb",  F_B,  32'h2000, 32'hFFFF_FFF1);
    do_load("lbu", F_BU, 32'h2000, 32'h0000_00F1);
    do_load("lh",  F_H,  32'h2002, 32'hFFFF_8765);
    do_load("lhu", F_HU, 32'h2002, 32'h0000_8765);
    do_load("lw",  F_W,  32'h2000, 32'h8765_43F1);
    do_load("lb3", F_B,  32'h2003, 32'hFFFF_FF87);

    // Partial stores preserve unselected bytes.
    do_store(F_W, 32'h2000, 32'h1111_1111);
    do_store(F_B, 32'h2001, 32'h0000_00AA);
    do_load("sb_merge", F_W, 32'h2000, 32'h1111_AA11);
    do_store(F_H, 32'h2002, 32'h0000_BEEF);
    do_load("sh_merge", F_W, 32'h2000, 32'hBEEF_AA11);

    // HEX digits; bit 7 of each byte is dropped.
    do_store(F_W, 32'h7020, 32'h7F06_5B4F);
    check("hex0", 32'(o_io_hex0), 32'h4F);
    check("hex1", 32'(o_io_hex1), 32'h5B);
    check("hex2", 32'(o_io_hex2), 32'h06);
    check("hex3", 32'(o_io_hex3), 32'h7F);
    do_load("hex_lw",  F_W,  32'h7020, 32'h7F06_5B4F);
    do_load("hex_lbu", F_BU, 32'h7021, 32'h0000_005B);
    do_store(F_W, 32'h7024, 32'hFFFF_FFFF);
    do_load("hex_bit7", F_W, 32'h7024, 32'h7F7F_7F7F);
    check("hex7", 32'(o_io_hex7), 32'h7F);

    // Misaligned and illegal accesses.
    probe_mis("mis_lw",  F_W,  32'h2002, 1'b0, 1'b1);
    do_load("mis_lw_data", F_W, 32'h2002, 32'h0);
    probe_mis("mis_sh",  F_H,  32'h2001, 1'b1, 1'b1);
    do_load("mis_sh_mem", F_W, 32'h2000, 32'hBEEF_AA11);
    probe_mis("ill_f3",  F_XX, 32'h2000, 1'b0, 1'b1);
    probe_mis("ok_lhu",  F_HU, 32'h2002, 1'b0, 1'b0);

    // Store then load same address: old data visible until the edge.
    bus.i_lsu_wren = 1'b1;
    bus.i_funct3   = F_W;
    bus.i_lsu_addr = 32'h2100;
    bus.i_st_data  = 32'h0BAD_F00D;
    #1;
    do_store(F_W, 32'h2100, 32'h0BAD_F00D);
    do_store(F_W, 32'h2100, 32'hA5A5_5A5A);
    bus.i_lsu_wren = 1'b1;
    bus.i_st_data  = 32'h1234_0000;
    #2;
    check("rd_old", bus.o_ld_data, 32'hA5A5_5A5A);
    @(posedge i_clk);
    #1;
    bus.i_lsu_wren = 1'b0;
    do_load("rd_new", F_W, 32'h2100, 32'h1234_0000);

    // Switch synchronizer latency; switch register is read-only.
    i_io_sw  = 32'h1234_5678;
    i_io_btn = 4'hA;
    repeat (3) @(posedge i_clk);
    #1;
    do_load("btn", F_W, 32'h7810, 32'h0000_000A);
    i_io_sw = 32'h0000_00FF;
    do_load("sw_n",   F_W, 32'h7800, 32'h1234_5678);
    do_load("sw_n1",  F_W, 32'h7800, 32'h1234_5678);
    do_load("sw_n2",  F_W, 32'h7800, 32'h0000_00FF);
    do_store(F_W, 32'h7800, 32'hDEAD_BEEF);
    do_load("sw_ro",  F_W, 32'h7800, 32'h0000_00FF);

    // Reset drops a concurrent DMEM store and clears LEDR.
    do_store(F_W, 32'h7000, 32'hFFFF_FFFF);
    check("ledr_set", o_io_ledr, 32'hFFFF_FFFF);
    do_store(F_W, 32'h2000, 32'hCAFE_BABE);
    i_rst_n        = 1'b0;
    bus.i_lsu_wren = 1'b1;
    bus.i_funct3   = F_W;
    bus.i_lsu_addr = 32'h2000;
    bus.i_st_data  = 32'hDEAD_DEAD;
    #2;
    check("rst_ld_comb", bus.o_ld_data, 32'hCAFE_BABE);
    @(posedge i_clk);
    #1;
    bus.i_lsu_wren = 1'b0;
    do_load("rst_sw_rd", F_W, 32'h7800, 32'h0);
    i_rst_n = 1'b1;
    check("rst_ledr2", o_io_ledr, 32'h0);
    do_load("rst_dmem", F_W, 32'h2000, 32'hCAFE_BABE);

    // Unmapped store dropped, unmapped load reads 0.
    do_store(F_W, 32'h5000_7000, 32'h0000_0001);
    check("unmap_ledr", o_io_ledr, 32'h0);
    do_load("unmap_ld", F_W, 32'h5000_7000, 32'h0);
    do_store(F_W, 32'h7010, 32'h0000_5A5A);
    check("ledg", o_io_ledg, 32'h0000_5A5A);
    do_store(F_HU, 32'h7032, 32'h0000_C3C3);
    check("lcd_h", o_io_lcd, 32'hC3C3_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
